// File: rtl/throw_charge_ctl.sv
// throw_charge_ctl: button-hold ping-pong force charger that holds enable through a throw's flight, then cools down.
// Optional auto-release after CHARGE_MAX_TICKS charge ticks: define CHARGE_AUTO_RELEASE_EN.
module throw_charge_ctl #(
  parameter int TICK_DIV         = 650000,
  parameter int FORCE_STEP       = 10,
  parameter int FORCE_MAX        = 1000,
  parameter int FLIGHT_TIMEOUT   = 500,
  parameter int COOLDOWN_TICKS   = 50,
  parameter int CHARGE_MAX_TICKS = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       turn_active,
  input  logic       btn,
  input  logic       throw_done,
  output logic [9:0] throw_force,
  output logic       enable,
  output logic       charging,
  output logic       turn_over,
  output logic       timed_out
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int CM = (FLIGHT_TIMEOUT > COOLDOWN_TICKS) ? FLIGHT_TIMEOUT : COOLDOWN_TICKS;
  localparam int CW = $clog2(((CM > CHARGE_MAX_TICKS) ? CM : CHARGE_MAX_TICKS) + 1);
  typedef enum logic [1:0] {IDLE, CHARGE, FLIGHT, COOLDOWN} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic btn_d_q, press, release_b, tick;
  logic [PW-1:0] presc_q;
  logic [9:0] force_q, force_d, up_c, dn_c;
  logic [10:0] up_sum, dn_sum;
  logic dir_q, dir_d, timed_out_q, timed_out_d, turn_over_q, turn_over_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign press     = sync_q[1] & ~btn_d_q;
  assign release_b = ~sync_q[1] & btn_d_q;
  assign tick      = presc_q == PW'(TICK_DIV - 1);
  assign up_sum    = {1'b0, force_q} + 11'(FORCE_STEP);
  assign dn_sum    = {1'b0, force_q} - 11'(FORCE_STEP);
  assign up_c      = (up_sum >= 11'(FORCE_MAX)) ? 10'(FORCE_MAX) : up_sum[9:0];
  assign dn_c      = dn_sum[10] ? 10'd0 : dn_sum[9:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      btn_d_q     <= 1'b0;
      presc_q     <= '0;
      force_q     <= '0;
      dir_q       <= 1'b0;
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
      turn_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[0], btn};
      btn_d_q     <= sync_q[1];
      presc_q     <= tick ? '0 : presc_q + PW'(1);
      force_q     <= force_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
      turn_over_q <= turn_over_d;
    end
  end
  // dir_q: 0 = charging up, 1 = charging down
  always_comb begin
    state_d     = state_q;
    force_d     = force_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
    turn_over_d = 1'b0;
    case (state_q)
      IDLE: begin
        force_d = '0;
        if (press && turn_active) begin
          state_d     = CHARGE;
          dir_d       = 1'b0;
          cnt_d       = '0;
          timed_out_d = 1'b0;
        end
      end
      CHARGE: begin
        if (!turn_active) begin
          state_d = IDLE;
          force_d = '0;
        end else if (release_b) begin
          state_d = FLIGHT;
          cnt_d   = '0;
        end else if (tick) begin
          force_d = dir_q ? dn_c : up_c;
          dir_d   = dir_q ? (dn_c != '0) : (up_c == 10'(FORCE_MAX));
`ifdef CHARGE_AUTO_RELEASE_EN
          state_d = (cnt_q == CW'(CHARGE_MAX_TICKS - 1)) ? FLIGHT : CHARGE;
          cnt_d   = (cnt_q == CW'(CHARGE_MAX_TICKS - 1)) ? '0 : cnt_q + CW'(1);
`endif
        end
      end
      FLIGHT: begin
        if (throw_done || (tick && cnt_q == CW'(FLIGHT_TIMEOUT - 1))) begin
          state_d     = COOLDOWN;
          cnt_d       = '0;
          timed_out_d = !throw_done;
          turn_over_d = 1'b1;
        end else if (tick) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      COOLDOWN: begin
        if (tick) begin
          state_d = (cnt_q == CW'(COOLDOWN_TICKS - 1)) ? IDLE : COOLDOWN;
          force_d = (cnt_q == CW'(COOLDOWN_TICKS - 1)) ? '0 : force_q;
          cnt_d   = (cnt_q == CW'(COOLDOWN_TICKS - 1)) ? '0 : cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign throw_force = force_q;
  assign enable      = state_q == FLIGHT;
  assign charging    = state_q == CHARGE;
  assign turn_over   = turn_over_q;
  assign timed_out   = timed_out_q;
endmodule
